// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Purpose:
//   Multi-cycle initiator for the combinational ALU. Accepts one operation
//   request in IDLE and latches its operands and op code. It presents them to
//   the ALU and waits for the result to settle. It then captures zHI/zLOW and
//   issues single-cycle write strobes for the low word, and for the high word
//   on multiply/divide. A final DONE cycle pulses done and parks the ALU on the
//   no-op code.
//
//   State sequence:
//     IDLE -> LOAD -> EXEC (1 or 1+MULDIV_WAIT cycles) -> WB_LO
//          -> [WB_HI for mul/div] -> DONE -> IDLE
//
// Parameters:
//   MULDIV_WAIT  extra EXEC cycles for op 2 (mul) / op 3 (div), 0..15
//
// Optional feature macro:
//   ILLEGAL_OP_EN  when defined, op codes 12..31 skip EXEC/WB and finish with
//                  err=1 alongside done. When undefined, err is tied to 0 and
//                  every op code takes the normal single-EXEC path.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   clr       in   1   synchronous active-high reset / abort
//   start     in   1   request strobe, sampled only in IDLE
//   op        in   5   operation code (0 add .. 11 not)
//   a_in      in  32   operand A, captured with start
//   b_in      in  32   operand B, captured with start
//   alu_a     out 32   operand A to the ALU
//   alu_b     out 32   operand B to the ALU
//   alu_ctrl  out  5   ctrl code to the ALU (5'b11111 = idle/no-op)
//   alu_zhi   in  32   ALU high result
//   alu_zlo   in  32   ALU low result
//   lo_out    out 32   captured low result
//   hi_out    out 32   captured high result
//   lo_we     out  1   low-word write strobe
//   hi_we     out  1   high-word write strobe
//   busy      out  1   operation in flight (any state but IDLE)
//   done      out  1   one-cycle completion pulse
//   err       out  1   illegal-op pulse (only with ILLEGAL_OP_EN)
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int unsigned MULDIV_WAIT = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [4:0]  op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_ctrl,
    input  logic [31:0] alu_zhi,
    input  logic [31:0] alu_zlo,
    output logic [31:0] lo_out,
    output logic [31:0] hi_out,
    output logic        lo_we,
    output logic        hi_we,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [4:0] C_CTRL_IDLE = 5'b11111;
    localparam logic [3:0] C_WAIT      = 4'(MULDIV_WAIT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EXEC  = 3'd2,
        S_WB_LO = 3'd3,
        S_WB_HI = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [4:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_alu_ctrl;
    logic [3:0]  r_wait_cnt;
    logic [31:0] r_lo;
    logic [31:0] r_hi;

    logic        w_accept;
    logic        w_is_muldiv;
    logic        w_exec_last;
    logic        w_is_illegal;

    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_is_muldiv = (r_op == 5'd2) || (r_op == 5'd3);
    assign w_exec_last = (r_wait_cnt == 4'd0);

`ifdef ILLEGAL_OP_EN
    assign w_is_illegal = (r_op >= 5'd12);
`else
    assign w_is_illegal = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others; blocking here would create order-
    // dependent simulation and mismatch the synthesised flops.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: the default assignment first guarantees every path writes
    // w_next_state, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next_state = S_LOAD;
            S_LOAD:  w_next_state = w_is_illegal ? S_DONE : S_EXEC;
            S_EXEC:  if (w_exec_last) w_next_state = S_WB_LO;
            S_WB_LO: w_next_state = w_is_muldiv ? S_WB_HI : S_DONE;
            S_WB_HI: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers: request latches, ALU drive, wait counter, results
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_alu_ctrl <= C_CTRL_IDLE;
            r_wait_cnt <= '0;
            r_lo       <= '0;
            r_hi       <= '0;
        end else begin
            // The ALU drive registers load on the accepting edge itself so the
            // operands and ctrl code are already valid throughout LOAD.
            if (w_accept) begin
                r_op       <= op;
                r_a        <= a_in;
                r_b        <= b_in;
                r_alu_ctrl <= op;
            end else if (w_next_state == S_DONE) begin
                // Covers both the normal WB exit and the illegal-op shortcut.
                r_alu_ctrl <= C_CTRL_IDLE;
            end

            // Counter is armed in LOAD so EXEC sees the full wait count on its
            // first cycle; zero means "this is the last EXEC cycle".
            if (r_state == S_LOAD) begin
                r_wait_cnt <= w_is_muldiv ? C_WAIT : 4'd0;
            end else if (r_state == S_EXEC && !w_exec_last) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end

            // Both result words are captured for every op; only mul/div
            // later strobe the high word out.
            if (r_state == S_EXEC && w_exec_last) begin
                r_lo <= alu_zlo;
                r_hi <= alu_zhi;
            end
        end
    end

    assign alu_a    = r_a;
    assign alu_b    = r_b;
    assign alu_ctrl = r_alu_ctrl;
    assign lo_out   = r_lo;
    assign hi_out   = r_hi;

    // -----------------------------------------------------------------------
    // Moore outputs decoded from the state register
    // -----------------------------------------------------------------------
    always_comb begin
        lo_we = 1'b0;
        hi_we = 1'b0;
        busy  = 1'b1;
        done  = 1'b0;
        err   = 1'b0;
        unique case (r_state)
            S_IDLE:  busy  = 1'b0;
            S_WB_LO: lo_we = 1'b1;
            S_WB_HI: hi_we = 1'b1;
            S_DONE: begin
                done = 1'b1;
                err  = w_is_illegal;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//
// Scoreboard bench for alu_sequencer. Stimulus tasks push the expected lo_we /
// hi_we / done events (cycle number and value) into queues when a request is
// accepted. A negedge monitor pops and compares whenever a strobe appears,
// and flags any strobe that has no pending expectation. A small behavioural
// ALU drives alu_zhi/alu_zlo from the DUT's alu_* outputs.
//
// Cycle numbering: with the accepting edge at cyc == A, the cycle the
// design calls "cycle k" is observed at the negedge where cyc == A + k - 1.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [4:0]  op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_ctrl;
    logic [31:0] alu_zhi;
    logic [31:0] alu_zlo;
    logic [31:0] lo_out;
    logic [31:0] hi_out;
    logic        lo_we;
    logic        hi_we;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    alu_sequencer #(.MULDIV_WAIT(W)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_ctrl (alu_ctrl),
        .alu_zhi  (alu_zhi),
        .alu_zlo  (alu_zlo),
        .lo_out   (lo_out),
        .hi_out   (hi_out),
        .lo_we    (lo_we),
        .hi_we    (hi_we),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // Behavioural ALU; unlisted ctrl codes return a recognisable marker.
    logic [63:0] prod;
    always_comb begin
        prod    = {32'd0, alu_a} * {32'd0, alu_b};
        alu_zhi = 32'd0;
        alu_zlo = 32'hDEAD_BEEF;
        case (alu_ctrl)
            5'd0: alu_zlo = alu_a + alu_b;
            5'd1: alu_zlo = alu_a - alu_b;
            5'd2: {alu_zhi, alu_zlo} = prod;
            5'd3: if (alu_b != 32'd0) begin
                alu_zlo = alu_a / alu_b;
                alu_zhi = alu_a % alu_b;
            end
            5'd8: alu_zlo = alu_a & alu_b;
            5'd9: alu_zlo = alu_a | alu_b;
            default: ;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } exp_t;

    exp_t q_lo[$];
    exp_t q_hi[$];
    exp_t q_done[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compares every strobe against the head of its queue.
    exp_t m_e;
    always @(negedge clk) begin
        if (lo_we) begin
            if (q_lo.size() == 0) check("lo_we_unexpected", 64'(lo_we), 64'd0);
            else begin
                m_e = q_lo.pop_front();
                check("lo_we_cycle", 64'(cyc), 64'(m_e.cyc));
                check("lo_out", 64'(lo_out), 64'(m_e.val));
            end
        end
        if (hi_we) begin
            if (q_hi.size() == 0) check("hi_we_unexpected", 64'(hi_we), 64'd0);
            else begin
                m_e = q_hi.pop_front();
                check("hi_we_cycle", 64'(cyc), 64'(m_e.cyc));
                check("hi_out", 64'(hi_out), 64'(m_e.val));
            end
        end
        if (done) begin
            if (q_done.size() == 0) check("done_unexpected", 64'(done), 64'd0);
            else begin
                m_e = q_done.pop_front();
                check("done_cycle", 64'(cyc), 64'(m_e.cyc));
                check("done_err", 64'(err), 64'(m_e.val[0]));
            end
        end
        if (err && !done) check("err_stray", 64'(err), 64'd0);
    end

    // Drives one start pulse; acc is the edge index that samples it.
    task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int acc);
        @(negedge clk);
        op    = o;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        acc   = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Pushes the expected strobes for a request accepted at edge acc.
    task automatic expect_op(input int acc, input logic [4:0] o,
                             input logic [31:0] lo, input logic [31:0] hi);
        if (o == 5'd2 || o == 5'd3) begin
            q_lo.push_back('{cyc: acc + 2 + W, val: lo});
            q_hi.push_back('{cyc: acc + 3 + W, val: hi});
            q_done.push_back('{cyc: acc + 4 + W, val: 32'd0});
        end
`ifdef ILLEGAL_OP_EN
        else if (o >= 5'd12) begin
            q_done.push_back('{cyc: acc + 1, val: 32'd1});
        end
`endif
        else begin
            q_lo.push_back('{cyc: acc + 2, val: lo});
            q_done.push_back('{cyc: acc + 3, val: 32'd0});
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60 && (q_lo.size() + q_hi.size() + q_done.size()) != 0; i++)
            @(negedge clk);
        check(name, 64'(q_lo.size() + q_hi.size() + q_done.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    int acc;

    initial begin
        clr   = 1'b1;
        start = 1'b0;
        op    = 5'd0;
        a_in  = 32'd0;
        b_in  = 32'd0;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_alu_ctrl", 64'(alu_ctrl), 64'h1F);
        check("rst_strobes", 64'({lo_we, hi_we, done, err}), 64'd0);
        check("rst_alu_ab", {alu_a, alu_b}, 64'd0);
        check("rst_lo_hi", {hi_out, lo_out}, 64'd0);
        clr = 1'b0;
        repeat (2) @(negedge clk);

        // 1. Add 5 + 7.
        issue(5'd0, 32'd5, 32'd7, acc);
        expect_op(acc, 5'd0, 32'd12, 32'd0);
        check("add_load_ctrl", 64'(alu_ctrl), 64'd0);
        check("add_load_ab", {alu_a, alu_b}, {32'd5, 32'd7});
        check("add_load_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("add_exec_ctrl", 64'(alu_ctrl), 64'd0);
        repeat (2) @(negedge clk);
        check("add_done_ctrl", 64'(alu_ctrl), 64'h1F);
        wait_drain("add_drain");

        // 2. Multiply 0x10000 * 0x10000 -> hi=1, lo=0.
        issue(5'd2, 32'h0001_0000, 32'h0001_0000, acc);
        expect_op(acc, 5'd2, 32'd0, 32'd1);
        check("mul_busy_c1", 64'(busy), 64'd1);
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("mul_busy_c%0d", k), 64'(busy), (k <= 7) ? 64'd1 : 64'd0);
        end
        wait_drain("mul_drain");

        // 3. Busy rejection: sub 9-4, with starts in cycles 2 (EXEC) and 4 (DONE).
        issue(5'd1, 32'd9, 32'd4, acc);
        expect_op(acc, 5'd1, 32'd5, 32'd0);
        @(negedge clk);
        op    = 5'd0;
        a_in  = 32'd1;
        b_in  = 32'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain("rej_drain");
        repeat (6) @(negedge clk);
        check("rej_lo_out", 64'(lo_out), 64'd5);
        check("rej_busy", 64'(busy), 64'd0);

        // 4. Abort a divide in its second EXEC cycle.
        issue(5'd3, 32'd100, 32'd7, acc);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ctrl", 64'(alu_ctrl), 64'h1F);
        check("abort_lo_hi", {hi_out, lo_out}, 64'd0);
        repeat (10) @(negedge clk);
        check("abort_idle", 64'({busy, lo_we, hi_we, done}), 64'd0);

        // 5. Back-to-back AND with start held high: accepts every 5 edges.
        @(negedge clk);
        op    = 5'd8;
        a_in  = 32'h0000_F0F0;
        b_in  = 32'h0000_FF00;
        start = 1'b1;
        acc   = cyc + 1;
        for (int k = 0; k < 3; k++) expect_op(acc + 5 * k, 5'd8, 32'h0000_F000, 32'd0);
        for (int i = 0; i < 40 && cyc < acc + 14; i++) @(negedge clk);
        start = 1'b0;
        wait_drain("b2b_drain");
        check("b2b_lo_out", 64'(lo_out), 64'h0000_F000);

        // 6. Op 13.
        issue(5'd13, 32'd3, 32'd4, acc);
        expect_op(acc, 5'd13, 32'hDEAD_BEEF, 32'd0);
        wait_drain("op13_drain");
`ifdef ILLEGAL_OP_EN
        check("op13_lo_out", 64'(lo_out), 64'h0000_F000);
`else
        check("op13_lo_out", 64'(lo_out), 64'hDEAD_BEEF);
`endif
        check("op13_err_idle", 64'(err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
